pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter. Supports logical left, logical right,
//  arithmetic right and rotate right, with carry-out and zero flags.
//  It is the shift unit for the datapath ALU: one operation in per cycle,
//  fixed latency, and valid/ready handshakes on both sides.
//  Each shift stage (1,2,4,...) is registered, so the pipeline depth equals SHW.
// PARAMETERS
//  WIDTH  16               operand width; must be a power of 2 and >= 4
//  SHW    $clog2(WIDTH)    shift-amount width; also the number of pipeline stages (derived, do not override)
// PORTS
//  clk        in   1      single clock; all state updates on its rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input operation present
//  in_ready   out  1      shifter can accept the input this cycle
//  op         in   WIDTH  operand
//  shift_mag  in   SHW    shift amount, 0..WIDTH-1
//  mode       in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts the result
//  result     out  WIDTH  shifted value
//  carry      out  1      last bit shifted out; 0 when shift_mag==0
//  zero       out  1      result == 0
// BEHAVIOUR
//  - Reset (async, any time): all stage valid bits cleared, so out_valid=0.
//    result, carry, zero and all stage data are cleared to 0.
//    in_ready=1 as soon as rst deasserts. An operation in flight is discarded and never appears.
//  - Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
//    When adv=1, every stage register loads from the stage before it. When adv=0, all stages hold.
//  - Bubbles are not collapsed. A stage loads valid=0 when its predecessor is empty.
//  - Accept: handshake when in_valid && in_ready. Stage 0 captures op after the 2^0 shift step.
//    Stage k applies the 2^k step selected by shift_mag[k].
//    mode and shift_mag travel with the data through the stages.
//  - Latency: with no stall, the result is visible SHW-1 cycles after the accept edge
//    (WIDTH=16: accept at edge N, out_valid=1 after edge N+3). Throughput is 1/cycle.
//  - Output hold: while out_valid && !out_ready, result/carry/zero/out_valid stay stable.
//    Simultaneous accept and output drain in one cycle is legal and loses nothing.
//  - Stage step for amount s=2^k, when the bit is set:
//    LSL: shift left, fill 0.
//    LSR: shift right, fill 0.
//    ASR: shift right, fill with the original op[WIDTH-1], carried down the pipeline.
//    ROR: rotate right by s.
//  - carry, with n = shift_mag (n>0):
//    LSL = op[WIDTH-n]; LSR/ASR = op[n-1]; ROR = result[WIDTH-1].
//    carry=0 when n=0, for every mode.
//  - Carry is computed incrementally, per stage, from the bits dropped by the highest set step.
//  - zero is computed from the final stage value and registered with result.
//  - in_valid=0 cycles insert bubbles. Input values are ignored when not accepted.
// TESTING (WIDTH=16)
//  1. LSL op=0x8001 mag=1 -> result=0x0002 carry=1 zero=0, out_valid 3 cycles after accept.
//  2. LSR 0x8001>>1 -> 0x4000 c=1; ASR 0x8000 mag=15 -> 0xFFFF c=0;
//     ASR 0x4000 mag=15 -> 0x0000 c=1 zero=1.
//  3. ROR 0x1234 mag=4 -> 0x4123 c=0; ROR 0x1234 mag=0 -> 0x1234 c=0; LSL 0xFFFF mag=0 -> c=0.
//  4. Back-to-back: 8 ops on consecutive cycles with out_ready=1.
//     -> 8 results in order on consecutive cycles, matching the reference model.
//  5. Backpressure: hold out_ready=0 for 5 cycles with the pipeline full.
//     -> in_ready=0, outputs stable, no loss or duplication after release.
//     Random out_ready over 1000 random ops checked against the model.
//  6. Assert rst with 3 ops in flight.
//     -> out_valid=0 immediately (async) and result=0; none of the 3 ops appears after reset.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per power-of-two shift step.
// Supports LSL/LSR/ASR/ROR with carry-out and zero flags, and valid/ready on both sides.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op,
    input  logic [SHW-1:0]   shift_mag,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_e;

    logic                        adv;
    logic [SHW-1:0][WIDTH-1:0]   data_q, nxt_data;
    logic [SHW-1:0]              valid_q, nxt_valid;
    logic [SHW-1:0]              carry_q, nxt_carry;
    logic [SHW-2:0][SHW-1:0]     mag_q, nxt_mag;
    logic [SHW-2:0][1:0]         mode_q, nxt_mode;
    logic [SHW-2:0]              sign_q, nxt_sign;
    logic                        zero_q;

    // The whole pipeline moves as one unit; a stalled output freezes every stage.
    assign adv       = !valid_q[SHW-1] || out_ready;
    assign in_ready  = adv;
    assign nxt_valid = {valid_q[SHW-2:0], in_valid};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;

        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] stepped;
        logic [1:0]       src_mode;
        logic             src_bit;
        logic             src_sign;
        logic             src_carry;
        logic             step_carry;

        if (k == 0) begin : g_head
            assign src         = op;
            assign src_mode    = mode;
            assign src_bit     = shift_mag[0];
            assign src_sign    = op[WIDTH-1];
            assign src_carry   = 1'b0;
            assign nxt_mag[0]  = shift_mag;
            assign nxt_mode[0] = mode;
            assign nxt_sign[0] = op[WIDTH-1];
        end else begin : g_tail
            assign src       = data_q[k-1];
            assign src_mode  = mode_q[k-1];
            assign src_bit   = mag_q[k-1][k];
            assign src_sign  = sign_q[k-1];
            assign src_carry = carry_q[k-1];
            if (k < SHW-1) begin : g_fwd
                assign nxt_mag[k]  = mag_q[k-1];
                assign nxt_mode[k] = mode_q[k-1];
                assign nxt_sign[k] = sign_q[k-1];
            end
        end

        // Carry is replaced only by a step that actually shifts, so the highest set step wins.
        always_comb begin
            stepped    = src;
            step_carry = src_carry;
            if (src_bit) begin
                case (src_mode)
                    MODE_LSL: begin
                        stepped    = {src[WIDTH-1-S:0], {S{1'b0}}};
                        step_carry = src[WIDTH-S];
                    end
                    MODE_LSR: begin
                        stepped    = {{S{1'b0}}, src[WIDTH-1:S]};
                        step_carry = src[S-1];
                    end
                    MODE_ASR: begin
                        stepped    = {{S{src_sign}}, src[WIDTH-1:S]};
                        step_carry = src[S-1];
                    end
                    MODE_ROR: begin
                        stepped    = {src[S-1:0], src[WIDTH-1:S]};
                        step_carry = src[S-1];
                    end
                endcase
            end
        end

        assign nxt_data[k]  = stepped;
        assign nxt_carry[k] = step_carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            carry_q <= '0;
            mag_q   <= '0;
            mode_q  <= '0;
            sign_q  <= '0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            data_q  <= nxt_data;
            valid_q <= nxt_valid;
            carry_q <= nxt_carry;
            mag_q   <= nxt_mag;
            mode_q  <= nxt_mode;
            sign_q  <= nxt_sign;
            zero_q  <= (nxt_data[SHW-1] == '0);
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign result    = data_q[SHW-1];
    assign carry     = carry_q[SHW-1];
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomised checks of pipelined_barrel_shifter (WIDTH=16) against
// hand-computed vectors and an independent whole-shift reference model.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op;
    logic [SHW-1:0]   shift_mag;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    int checks     = 0;
    int errors     = 0;
    int pop_count  = 0;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .shift_mag (shift_mag),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    // Whole-operation reference: {carry, zero, result}.
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [3:0] n,
                                              input logic [1:0] md);
        logic [15:0] r;
        logic [15:0] t;
        logic        c;
        int          ni;
        ni = int'(n);
        r  = a;
        c  = 1'b0;
        case (md)
            2'b00: begin
                r = a << ni;
                t = a >> (16 - ni);
                c = (ni != 0) && t[0];
            end
            2'b01: begin
                r = a >> ni;
                t = (ni == 0) ? 16'h0 : (a >> (ni - 1));
                c = t[0];
            end
            2'b10: begin
                r = $signed(a) >>> ni;
                t = (ni == 0) ? 16'h0 : (a >> (ni - 1));
                c = t[0];
            end
            default: begin
                r = (a >> ni) | (a << (16 - ni));
                c = (ni != 0) && r[15];
            end
        endcase
        return {c, (r == 16'h0), r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [15:0] o, input logic [3:0] m,
                                 input logic [1:0] md, input logic ordy);
        in_valid  = iv;
        op        = o;
        shift_mag = m;
        mode      = md;
        out_ready = ordy;
    endtask

    // One clock of streaming traffic, scored against the queue of expected results.
    task automatic cycle_step(input logic iv, input logic [15:0] o, input logic [3:0] m,
                              input logic [1:0] md, input logic ordy, output logic accepted);
        logic [17:0] exp;
        @(negedge clk);
        applyStimulus(iv, o, m, md, ordy);
        #1;
        checkOutput("in_ready", in_ready, !out_valid || ordy);
        if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out_valid", out_valid, 0);
            end else begin
                exp = sb[0];
                checkOutput("stream_result", result, exp[15:0]);
                checkOutput("stream_carry", carry, exp[17]);
                checkOutput("stream_zero", zero, exp[16]);
                if (ordy) begin
                    void'(sb.pop_front());
                    pop_count++;
                end
            end
        end
        accepted = iv && in_ready;
        if (accepted) sb.push_back(ref_model(o, m, md));
    endtask

    task automatic drain_all(input string tag);
        logic acc;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle_step(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, acc);
            n++;
        end
        checkOutput(tag, sb.size(), 0);
    endtask

    // Single isolated op: checks latency and the hand-computed result.
    task automatic run_single(input string tag, input logic [15:0] o, input logic [3:0] m,
                              input logic [1:0] md, input logic [15:0] exp_res,
                              input logic exp_c, input logic exp_z);
        @(negedge clk);
        applyStimulus(1'b1, o, m, md, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
        repeat (2) begin
            @(negedge clk);
            checkOutput({tag, "_early_valid"}, out_valid, 0);
        end
        @(negedge clk);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_carry"}, carry, exp_c);
        checkOutput({tag, "_zero"}, zero, exp_z);
    endtask

    initial begin
        logic acc;
        int   base;
        int   n_acc;
        int   cyc;

        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result", result, 16'h0);
        checkOutput("reset_carry", carry, 0);
        checkOutput("reset_zero", zero, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed single operations");
        run_single("lsl_8001_1",  16'h8001, 4'd1,  2'b00, 16'h0002, 1'b1, 1'b0);
        run_single("lsr_8001_1",  16'h8001, 4'd1,  2'b01, 16'h4000, 1'b1, 1'b0);
        run_single("asr_8000_15", 16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b0);
        run_single("asr_4000_15", 16'h4000, 4'd15, 2'b10, 16'h0000, 1'b1, 1'b1);
        run_single("ror_1234_4",  16'h1234, 4'd4,  2'b11, 16'h4123, 1'b0, 1'b0);
        run_single("ror_1234_0",  16'h1234, 4'd0,  2'b11, 16'h1234, 1'b0, 1'b0);
        run_single("lsl_ffff_0",  16'hFFFF, 4'd0,  2'b00, 16'hFFFF, 1'b0, 1'b0);
        run_single("lsl_0001_15", 16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0, 1'b0);
        run_single("lsr_8000_15", 16'h8000, 4'd15, 2'b01, 16'h0001, 1'b0, 1'b0);
        run_single("ror_0001_1",  16'h0001, 4'd1,  2'b11, 16'h8000, 1'b1, 1'b0);
        run_single("lsl_4001_2",  16'h4001, 4'd2,  2'b00, 16'h0004, 1'b1, 1'b0);

        $display("[TB] back-to-back stream");
        @(negedge clk);
        base = pop_count;
        for (int i = 0; i < 8; i++) begin
            cycle_step(1'b1, 16'h9AC5 + 16'(i * 16'h1357), 4'(i * 5), 2'(i), 1'b1, acc);
            checkOutput("b2b_accept", acc, 1);
        end
        repeat (4) cycle_step(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, acc);
        checkOutput("b2b_count", pop_count - base, 8);
        checkOutput("b2b_empty", sb.size(), 0);

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++)
            cycle_step(1'b1, 16'hC3A1 ^ 16'(i * 16'h0F0F), 4'(3 + i * 4), 2'(i + 2), 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            cycle_step(1'b1, 16'hDEAD, 4'd7, 2'b10, 1'b0, acc);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_accept", acc, 0);
        end
        drain_all("bp_drain_empty");

        $display("[TB] random traffic");
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 6000) begin
            cycle_step($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 2'($urandom),
                       $urandom_range(0, 2) != 0, acc);
            if (acc) n_acc++;
            cyc++;
        end
        checkOutput("random_accepted", n_acc, 1000);
        drain_all("random_drain_empty");

        $display("[TB] reset with ops in flight");
        cycle_step(1'b1, 16'h00F0, 4'd4, 2'b00, 1'b0, acc);
        cycle_step(1'b1, 16'h1234, 4'd1, 2'b01, 1'b0, acc);
        cycle_step(1'b1, 16'h8421, 4'd3, 2'b11, 1'b0, acc);
        cycle_step(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, acc);
        @(posedge clk);
        #2;
        checkOutput("rst_pre_valid", out_valid, 1);
        checkOutput("rst_pre_result", result, 16'h0F00);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", out_valid, 0);
        checkOutput("rst_async_result", result, 16'h0);
        checkOutput("rst_async_carry", carry, 0);
        checkOutput("rst_async_zero", zero, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            cycle_step(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, acc);
            checkOutput("rst_no_ghost", out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
